btb_update_ctrl: RTL and testbench

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

---
 rtl/btb_update_ctrl_if.sv | 31 +++
 rtl/btb_update_ctrl.sv | 129 ++++++++++++
 tb/tb_btb_update_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/btb_update_ctrl_if.sv
// Signal bundle for the BTB update controller: EX update channel, IF lookup
// arbitration, flush control, shared array port and set-update logic hookup.
interface btb_update_ctrl_if;
  logic         upd_valid, upd_ready, upd_mispredicted;
  logic [31:0]  upd_pc, upd_target;
  logic         lookup_req, lookup_grant;
  logic [2:0]   lookup_index;
  logic         flush_req, flush_busy;
  logic         arr_en, arr_we;
  logic [2:0]   arr_index;
  logic [127:0] arr_wdata, arr_rdata;
  logic [127:0] wb_set, wb_write_set;
  logic [26:0]  wb_tag;
  logic [2:0]   wb_index;
  logic [31:0]  wb_target;
  logic         wb_mispredicted, wb_next_lru;
  logic [7:0]   lru;

  modport master (
    output upd_valid, upd_pc, upd_target, upd_mispredicted, lookup_req, lookup_index,
           flush_req, arr_rdata, wb_write_set, wb_next_lru,
    input  upd_ready, lookup_grant, flush_busy, arr_en, arr_we, arr_index, arr_wdata,
           wb_set, wb_tag, wb_index, wb_target, wb_mispredicted, lru
  );
  modport slave (
    input  upd_valid, upd_pc, upd_target, upd_mispredicted, lookup_req, lookup_index,
           flush_req, arr_rdata, wb_write_set, wb_next_lru,
    output upd_ready, lookup_grant, flush_busy, arr_en, arr_we, arr_index, arr_wdata,
           wb_set, wb_tag, wb_index, wb_target, wb_mispredicted, lru
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// Serialises branch-resolution updates into read-modify-write cycles on the
// single-port BTB array, sharing the port with IF lookups and a sweep flush.
module btb_update_ctrl (
  input logic             clk,
  input logic             rst,
  btb_update_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RD_WAIT = 2'd1, WRITE = 2'd2, FLUSH = 2'd3;

  typedef struct packed {
    logic [26:0] tag;
    logic [2:0]  idx;
    logic [31:0] target;
    logic        mis;
  } upd_ent_t;

  upd_ent_t     fifo_q [2];
  upd_ent_t     head, push_ent;
  logic [1:0]   state_q, state_d, cnt_q;
  logic         wr_ptr_q, rd_ptr_q;
  logic [2:0]   fcnt_q;
  logic [7:0]   lru_q;
  logic [127:0] set_q;
  logic         full, empty, push, pop, grant, en, we, wb_act;
  logic [2:0]   idx;
  logic [127:0] wdata;

  assign head     = fifo_q[rd_ptr_q];
  assign push_ent = '{tag: bus.upd_pc[31:5], idx: bus.upd_pc[4:2],
                      target: bus.upd_target, mis: bus.upd_mispredicted};
  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign bus.upd_ready = !full && (state_q != FLUSH) && !bus.flush_req;
  assign push     = bus.upd_valid && bus.upd_ready;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    en      = 1'b0;
    we      = 1'b0;
    idx     = 3'd0;
    wdata   = '0;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!bus.flush_req) begin
        // a full FIFO takes the port from lookups so updates cannot starve
        if (bus.lookup_req && !full) grant = 1'b1;
        else if (!empty) begin
          en      = 1'b1;
          idx     = head.idx;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (!bus.flush_req) begin
        grant   = bus.lookup_req;
        state_d = WRITE;
      end
      WRITE: if (!bus.flush_req) begin
        en      = 1'b1;
        we      = 1'b1;
        idx     = head.idx;
        wdata   = bus.wb_write_set;
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: begin
        en  = 1'b1;
        we  = 1'b1;
        idx = fcnt_q;
        if (fcnt_q == 3'd7) state_d = IDLE;
      end
    endcase
    if (grant) begin
      en  = 1'b1;
      idx = bus.lookup_index;
    end
    if (bus.flush_req) state_d = FLUSH;
  end

  assign bus.lookup_grant = grant;
  assign bus.flush_busy   = (state_q == FLUSH);
  assign bus.arr_en       = en;
  assign bus.arr_we       = we;
  assign bus.arr_index    = idx;
  assign bus.arr_wdata    = wdata;
  assign bus.lru          = lru_q;

  // set-update logic only sees live operands while a write is really going out
  assign wb_act              = (state_q == WRITE) && !bus.flush_req;
  assign bus.wb_set          = wb_act ? set_q : '0;
  assign bus.wb_tag          = wb_act ? head.tag : '0;
  assign bus.wb_index        = wb_act ? head.idx : '0;
  assign bus.wb_target       = wb_act ? head.target : '0;
  assign bus.wb_mispredicted = wb_act && head.mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fcnt_q   <= 3'd0;
      lru_q    <= 8'h00;
      set_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_WAIT) set_q <= bus.arr_rdata;
      if (bus.flush_req) begin
        cnt_q    <= 2'd0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        fcnt_q   <= 3'd0;
        lru_q    <= 8'h00;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop) begin
          rd_ptr_q          <= ~rd_ptr_q;
          lru_q[head.idx]   <= bus.wb_next_lru;
        end
        cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        if (state_q == FLUSH) fcnt_q <= fcnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_ent;
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Random and directed stimulus for btb_update_ctrl against a queue-based model.
module tb_btb_update_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btb_update_ctrl_if bus ();
  btb_update_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [26:0] tag;
    logic [2:0]  idx;
    logic [31:0] tgt;
    logic        mis;
  } ent_t;

  int unsigned  n_chk = 0, n_fail = 0;
  logic [127:0] arr_mem [8];
  logic [127:0] exp_mem [8];
  ent_t         q[$];
  int           stage;
  logic         fl_on;
  logic [2:0]   fl_pos;
  logic [7:0]   mlru;

  function automatic logic [127:0] init_val(input int i);
    return {4{32'hA5C3_0000 + 32'(i) * 32'h0101_0011}};
  endfunction

  function automatic logic [128:0] upd_fn(input logic [127:0] s, input logic [26:0] t,
                                          input logic [2:0] i, input logic [31:0] g,
                                          input logic m, input logic lb);
    return {^g ^ m ^ ~lb, s[95:0], g ^ {t, i, m, 1'b1}};
  endfunction

  // stand-in for the combinational set-update logic
  always_comb begin
    {bus.wb_next_lru, bus.wb_write_set} = upd_fn(bus.wb_set, bus.wb_tag, bus.wb_index,
      bus.wb_target, bus.wb_mispredicted, bus.lru[bus.wb_index]);
  end

  // single-port array, read data one cycle after the access
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) arr_mem[i] <= init_val(i);
    end else if (bus.arr_en) begin
      if (bus.arr_we) arr_mem[bus.arr_index] <= bus.arr_wdata;
      else            bus.arr_rdata <= arr_mem[bus.arr_index];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_rst_outs();
    chk("rst_ready", bus.upd_ready, 1);
    chk("rst_grant", bus.lookup_grant, 0);
    chk("rst_busy", bus.flush_busy, 0);
    chk("rst_arr", {bus.arr_en, bus.arr_we, bus.arr_index, bus.arr_wdata}, 0);
    chk("rst_wb", {bus.wb_set, bus.wb_tag, bus.wb_index, bus.wb_target, bus.wb_mispredicted}, 0);
    chk("rst_lru", bus.lru, 0);
  endtask

  task automatic mdl_reset();
    q.delete();
    stage  = 0;
    fl_on  = 0;
    fl_pos = 0;
    mlru   = 0;
    for (int i = 0; i < 8; i++) exp_mem[i] = init_val(i);
  endtask

  // one clock: drive at posedge+1, check at negedge, advance the model
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic mis, input logic lr, input logic [2:0] li, input logic fr);
    ent_t e;
    logic full, rdy, g, en, we, wr, rd;
    logic [2:0] ix;
    logic [127:0] wd;
    logic [128:0] r;
    bus.upd_valid = v; bus.upd_pc = pc; bus.upd_target = tgt; bus.upd_mispredicted = mis;
    bus.lookup_req = lr; bus.lookup_index = li; bus.flush_req = fr;
    @(negedge clk);
    full = (q.size() == 2);
    rdy  = !full && !fl_on && !fr;
    g = 0; en = 0; we = 0; wr = 0; rd = 0; ix = 0; wd = 0; r = 0;
    e = '{tag: 0, idx: 0, tgt: 0, mis: 0};
    if (fl_on) begin
      en = 1; we = 1; ix = fl_pos;
    end else if (!fr) begin
      if (stage == 2) begin
        e = q[0];
        r = upd_fn(exp_mem[e.idx], e.tag, e.idx, e.tgt, e.mis, mlru[e.idx]);
        en = 1; we = 1; ix = e.idx; wd = r[127:0]; wr = 1;
      end else if (stage == 1) g = lr;
      else if (lr && !full) g = 1;
      else if (q.size() > 0) begin en = 1; ix = q[0].idx; rd = 1; end
      if (g) begin en = 1; ix = li; end
    end
    chk("upd_ready", bus.upd_ready, rdy);
    chk("lookup_grant", bus.lookup_grant, g);
    chk("flush_busy", bus.flush_busy, fl_on);
    chk("arr_en_we", {bus.arr_en, bus.arr_we}, {en, we});
    chk("arr_index", bus.arr_index, ix);
    chk("arr_wdata", bus.arr_wdata, wd);
    chk("lru", bus.lru, mlru);
    if (wr) begin
      chk("wb_set", bus.wb_set, exp_mem[e.idx]);
      chk("wb_fields", {bus.wb_tag, bus.wb_index, bus.wb_target, bus.wb_mispredicted},
          {e.tag, e.idx, e.tgt, e.mis});
    end else begin
      chk("wb_idle", {bus.wb_set, bus.wb_tag, bus.wb_index, bus.wb_target, bus.wb_mispredicted}, 0);
    end
    if (fl_on) exp_mem[fl_pos] = '0;
    if (fr) begin
      q.delete(); stage = 0; fl_on = 1; fl_pos = 0; mlru = 0;
    end else if (fl_on) begin
      if (fl_pos == 3'd7) fl_on = 0;
      fl_pos = fl_pos + 3'd1;
    end else if (stage == 2) begin
      exp_mem[e.idx] = r[127:0];
      mlru[e.idx] = r[128];
      void'(q.pop_front());
      stage = 0;
    end else if (stage == 1) stage = 2;
    else if (rd) stage = 1;
    if (v && rdy) q.push_back('{tag: pc[31:5], idx: pc[4:2], tgt: tgt, mis: mis});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_target = 0; bus.upd_mispredicted = 0;
    bus.lookup_req = 0; bus.lookup_index = 0; bus.flush_req = 0;
    #1 chk_rst_outs();
    @(posedge clk); #1;
    chk_rst_outs();
    rst = 1'b0;
    mdl_reset();

    // single update at index 5
    cyc(1, 32'h0000_0014, 32'hDEAD_BEEF, 1, 0, 0, 0);
    idle(5);
    // lookups held while two updates queue up
    cyc(1, 32'h1000_0008, 32'h1111_2222, 0, 1, 3'd2, 0);
    cyc(1, 32'h2000_001C, 32'h3333_4444, 1, 1, 3'd6, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 3'(i), 0);
    idle(4);
    // back-to-back updates to set 3
    cyc(1, 32'hABC0_000C, 32'h5555_6666, 0, 0, 0, 0);
    cyc(1, 32'h1234_560C, 32'h7777_8888, 1, 0, 0, 0);
    idle(8);
    // flush during RD_WAIT with an entry still queued
    cyc(1, 32'h0000_0004, 32'h9999_AAAA, 0, 0, 0, 0);
    cyc(1, 32'h0000_0018, 32'hBBBB_CCCC, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(10);

    // reset landing on a write cycle
    cyc(1, 32'h0000_0010, 32'hCAFE_F00D, 1, 0, 0, 0);
    idle(2);
    chk("pre_rst_we", bus.arr_we, 1);
    rst = 1'b1;
    #1;
    chk("rst_we_drop", bus.arr_we, 0);
    chk("rst_lru_clr", bus.lru, 0);
    chk("rst_ready", bus.upd_ready, 1);
    @(posedge clk); #1;
    chk_rst_outs();
    rst = 1'b0;
    mdl_reset();

    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 60) == 0));
    end
    idle(12);
    for (int i = 0; i < 8; i++) chk("final_mem", arr_mem[i], exp_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
